// File: rtl/gfx_tile_shift_feeder.sv
// Tile-row feeder for the two 74166 bitplane shift registers: prefetches one ROM row, loads it every 8th pixel.
// Latency: rom_req rises 1 clk after the buffer empties; buffer fills the clk after rom_ack; all outputs registered.
// Backpressure: rom_req is held until rom_ack (never withdrawn); a load that finds the buffer empty shifts zeros and sets underrun.
//
// Ports:
//   clk, Reset_n          system clock, synchronous active-low reset
//   i_pxl_cen             pixel-slot strobe (shift registers clock on the same pulse)
//   i_hblank              horizontal blank
//   i_line_start          line restart pulse, only during hblank
//   i_tile_addr / o_tile_adv   next tile-row address, pulse asks upstream for the following one
//   o_rom_req, o_rom_addr, i_rom_ack, i_rom_data   ROM arbiter handshake
//   o_sr_d0, o_sr_d1, o_sr_sh_ldn, o_sr_inh, o_sr_clrn   shift register controls
//   o_underrun            sticky late-data flag, cleared on line_start
module gfx_tile_shift_feeder #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          i_pxl_cen,
  input  logic          i_hblank,
  input  logic          i_line_start,
  input  logic [AW-1:0] i_tile_addr,
  output logic          o_tile_adv,
  output logic          o_rom_req,
  output logic [AW-1:0] o_rom_addr,
  input  logic          i_rom_ack,
  input  logic [15:0]   i_rom_data,
  output logic [7:0]    o_sr_d0,
  output logic [7:0]    o_sr_d1,
  output logic          o_sr_sh_ldn,
  output logic          o_sr_inh,
  output logic          o_sr_clrn,
  output logic          o_underrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DISCARD, S_FULL} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_buf;
  logic          r_buf_valid;
  logic          r_primed;
  logic          r_prime_pend;   // prime load issued, waiting for the pxl_cen that performs it
  logic [2:0]    r_px;
  logic          r_tile_adv, r_rom_req, r_sh_ldn, r_inh, r_clrn, r_underrun;
  logic [AW-1:0] r_rom_addr;
  logic [7:0]    r_d0, r_d1;

  logic w_prime, w_load, w_consume, w_underrun;
  logic w_issue, w_capture, w_req_done;

  // line_start wins over any load in the same clk so a stale row is never primed
  assign w_prime    = i_pxl_cen & i_hblank & ~r_primed & ~r_prime_pend & r_buf_valid & ~i_line_start;
  assign w_load     = i_pxl_cen & ~i_hblank & (r_px == 3'd6) & ~i_line_start;
  assign w_consume  = (w_prime | w_load) & r_buf_valid;
  assign w_underrun = w_load & ~r_buf_valid;

  // state register
  always_ff @(posedge clk) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:         if (!r_buf_valid) w_state_nxt = S_REQ;
      S_REQ: begin
        // ack together with line_start belongs to the old line: drop it
        if (i_rom_ack)         w_state_nxt = i_line_start ? S_IDLE : S_FULL;
        else if (i_line_start) w_state_nxt = S_WAIT_DISCARD;
      end
      S_WAIT_DISCARD: if (i_rom_ack) w_state_nxt = S_IDLE;
      S_FULL:         if (w_consume || i_line_start) w_state_nxt = S_IDLE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    w_issue    = (r_state == S_IDLE) && !r_buf_valid;
    w_capture  = (r_state == S_REQ) && i_rom_ack && !i_line_start;
    w_req_done = ((r_state == S_REQ) || (r_state == S_WAIT_DISCARD)) && i_rom_ack;
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_rom_req    <= 1'b0;
      r_rom_addr   <= '0;
      r_tile_adv   <= 1'b0;
      r_buf        <= '0;
      r_buf_valid  <= 1'b0;
      r_primed     <= 1'b0;
      r_prime_pend <= 1'b0;
      r_px         <= '0;
      r_d0         <= '0;
      r_d1         <= '0;
      r_sh_ldn     <= 1'b1;
      r_inh        <= 1'b1;
      r_clrn       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_tile_adv <= w_issue;
      r_clrn     <= ~i_line_start;

      if (w_issue) begin
        r_rom_req  <= 1'b1;
        r_rom_addr <= i_tile_addr;
      end else if (w_req_done) begin
        r_rom_req  <= 1'b0;
      end

      if (w_capture) r_buf <= i_rom_data;

      // capture only happens in REQ and consume only in FULL, so they never collide
      if (i_line_start)   r_buf_valid <= 1'b0;
      else if (w_capture) r_buf_valid <= 1'b1;
      else if (w_consume) r_buf_valid <= 1'b0;

      if (i_line_start)                r_px <= '0;
      else if (i_pxl_cen && !i_hblank) r_px <= r_px + 3'd1;

      if (i_line_start)                   r_primed <= 1'b0;
      else if (i_pxl_cen && r_prime_pend) r_primed <= 1'b1;

      if (i_line_start)   r_prime_pend <= 1'b0;
      else if (w_prime)   r_prime_pend <= 1'b1;
      else if (i_pxl_cen) r_prime_pend <= 1'b0;

      // empty buffer on a load shifts transparent pixels
      if (w_prime || w_load) begin
        r_d0 <= r_buf_valid ? r_buf[7:0]  : 8'h00;
        r_d1 <= r_buf_valid ? r_buf[15:8] : 8'h00;
      end

      // a half-finished prime is abandoned on line_start, so release the load strobe
      if (i_line_start)   r_sh_ldn <= 1'b1;
      else if (i_pxl_cen) r_sh_ldn <= ~(w_prime | w_load);

      if (i_pxl_cen) begin
        if (w_prime)           r_inh <= 1'b0;
        else if (r_prime_pend) r_inh <= 1'b1;
        else                   r_inh <= i_hblank;
      end

      if (i_line_start)    r_underrun <= 1'b0;
      else if (w_underrun) r_underrun <= 1'b1;
    end
  end

  assign o_tile_adv  = r_tile_adv;
  assign o_rom_req   = r_rom_req;
  assign o_rom_addr  = r_rom_addr;
  assign o_sr_d0     = r_d0;
  assign o_sr_d1     = r_d1;
  assign o_sr_sh_ldn = r_sh_ldn;
  assign o_sr_inh    = r_inh;
  assign o_sr_clrn   = r_clrn;
  assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_gfx_tile_shift_feeder.sv
// Directed bench for gfx_tile_shift_feeder: reset, prime, steady stream, underrun, abort, reset mid-request.
// One clk per step(); inputs driven before the edge, outputs sampled 1 ns after it.
// ROM responder acks after a programmable number of clks, data from a queue.
module tb_gfx_tile_shift_feeder;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          i_pxl_cen, i_hblank, i_line_start;
  logic [AW-1:0] i_tile_addr;
  logic          o_tile_adv, o_rom_req;
  logic [AW-1:0] o_rom_addr;
  logic          i_rom_ack;
  logic [15:0]   i_rom_data;
  logic [7:0]    o_sr_d0, o_sr_d1;
  logic          o_sr_sh_ldn, o_sr_inh, o_sr_clrn, o_underrun;

  always #5 clk = ~clk;

  gfx_tile_shift_feeder #(.AW(AW)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .i_pxl_cen(i_pxl_cen), .i_hblank(i_hblank), .i_line_start(i_line_start),
    .i_tile_addr(i_tile_addr), .o_tile_adv(o_tile_adv),
    .o_rom_req(o_rom_req), .o_rom_addr(o_rom_addr),
    .i_rom_ack(i_rom_ack), .i_rom_data(i_rom_data),
    .o_sr_d0(o_sr_d0), .o_sr_d1(o_sr_d1), .o_sr_sh_ldn(o_sr_sh_ldn),
    .o_sr_inh(o_sr_inh), .o_sr_clrn(o_sr_clrn), .o_underrun(o_underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // stimulus / monitor state
  int          cen_period = 0;
  int          cen_cnt    = 0;
  bit          rsp_en     = 1'b0;
  int          rsp_lat    = 2;
  int          req_age    = 0;
  logic [15:0] rom_q[$];
  logic [AW-1:0] ack_addr[16];
  int          n_ack = 0;
  int          n_adv = 0;
  int          n_req = 0;
  logic        prev_req = 1'b0;
  logic        prev_ldn = 1'b1;
  logic [15:0] prev_d   = 16'h0;
  logic [15:0] ld_log[16];
  int          fall_at[16];
  int          low_dur[16];
  int          n_ld = 0;
  int          cyc  = 0;
  int          d_glitch = 0;

  task automatic step();
    logic rst_at_edge;
    logic fell;
    if (cen_period != 0) begin
      i_pxl_cen = (cen_cnt == cen_period - 1);
      cen_cnt   = (cen_cnt + 1) % cen_period;
    end
    if (rsp_en) begin
      i_rom_ack = 1'b0;
      if (o_rom_req) begin
        req_age++;
        if (req_age >= rsp_lat) begin
          i_rom_ack = 1'b1;
          if (rom_q.size() > 0) i_rom_data = rom_q.pop_front();
          else                  i_rom_data = 16'h0F0F;
          if (n_ack < 16) ack_addr[n_ack] = o_rom_addr;
          n_ack++;
          req_age = 0;
        end
      end else begin
        req_age = 0;
      end
    end
    rst_at_edge = Reset_n;
    @(posedge clk);
    #1;
    cyc++;
    if (o_tile_adv) begin
      n_adv++;
      i_tile_addr = i_tile_addr + 1'b1;
    end
    if (o_rom_req && !prev_req) n_req++;
    fell = !o_sr_sh_ldn && prev_ldn;
    if (fell) begin
      if (n_ld < 16) begin
        ld_log[n_ld]  = {o_sr_d1, o_sr_d0};
        fall_at[n_ld] = cyc;
      end
      n_ld++;
    end
    if (o_sr_sh_ldn && !prev_ldn && n_ld > 0 && n_ld <= 16)
      low_dur[n_ld-1] = cyc - fall_at[n_ld-1];
    if (rst_at_edge && ({o_sr_d1, o_sr_d0} != prev_d) && !fell) d_glitch++;
    prev_req = o_rom_req;
    prev_ldn = o_sr_sh_ldn;
    prev_d   = {o_sr_d1, o_sr_d0};
  endtask

  initial begin
    Reset_n      = 1'b0;
    i_pxl_cen    = 1'b0;
    i_hblank     = 1'b1;
    i_line_start = 1'b0;
    i_tile_addr  = '0;
    i_rom_ack    = 1'b0;
    i_rom_data   = '0;

    // ---- reset with random inputs
    for (int i = 0; i < 3; i++) begin
      i_pxl_cen    = 1'($urandom);
      i_hblank     = 1'($urandom);
      i_line_start = 1'($urandom);
      i_tile_addr  = AW'($urandom);
      i_rom_ack    = 1'($urandom);
      i_rom_data   = 16'($urandom);
      step();
    end
    chk("rst_rom_req",  32'(o_rom_req),   32'h0);
    chk("rst_rom_addr", 32'(o_rom_addr),  32'h0);
    chk("rst_tile_adv", 32'(o_tile_adv),  32'h0);
    chk("rst_sr_d0",    32'(o_sr_d0),     32'h0);
    chk("rst_sr_d1",    32'(o_sr_d1),     32'h0);
    chk("rst_sh_ldn",   32'(o_sr_sh_ldn), 32'h1);
    chk("rst_inh",      32'(o_sr_inh),    32'h1);
    chk("rst_clrn",     32'(o_sr_clrn),   32'h0);
    chk("rst_underrun", 32'(o_underrun),  32'h0);

    // ---- prime during hblank
    rom_q.push_back(16'hA55A);
    rom_q.push_back(16'h1234);
    rom_q.push_back(16'h5678);
    rom_q.push_back(16'h9ABC);
    Reset_n      = 1'b1;
    i_pxl_cen    = 1'b0;
    i_hblank     = 1'b1;
    i_line_start = 1'b1;
    i_tile_addr  = 16'h00FF;
    i_rom_ack    = 1'b0;
    i_rom_data   = '0;
    rsp_en       = 1'b1;
    rsp_lat      = 2;
    step();
    chk("prime_req_rise", 32'(o_rom_req),  32'h1);
    chk("prime_req_addr", 32'(o_rom_addr), 32'h00FF);
    chk("prime_tile_adv", 32'(o_tile_adv), 32'h1);
    chk("prime_clrn_lo",  32'(o_sr_clrn),  32'h0);
    i_line_start = 1'b0;
    step();
    chk("prime_clrn_hi",  32'(o_sr_clrn),  32'h1);
    chk("prime_adv_once", 32'(o_tile_adv), 32'h0);
    chk("prime_req_hold", 32'(o_rom_req),  32'h1);
    step();                                   // ack of 16'hA55A at this edge
    chk("prime_req_drop", 32'(o_rom_req),  32'h0);
    i_pxl_cen = 1'b1;
    step();
    i_pxl_cen = 1'b0;
    chk("prime_d0",     32'(o_sr_d0),     32'h5A);
    chk("prime_d1",     32'(o_sr_d1),     32'hA5);
    chk("prime_ldn_lo", 32'(o_sr_sh_ldn), 32'h0);
    chk("prime_inh_lo", 32'(o_sr_inh),    32'h0);
    step();
    chk("prime_req2",      32'(o_rom_req),  32'h1);
    chk("prime_req2_addr", 32'(o_rom_addr), 32'h0100);
    i_pxl_cen = 1'b1;
    step();
    i_pxl_cen = 1'b0;
    chk("prime_ldn_hi", 32'(o_sr_sh_ldn), 32'h1);
    chk("prime_inh_hi", 32'(o_sr_inh),    32'h1);

    // ---- steady stream: pxl_cen every 4 clks, ack latency 3
    rsp_lat    = 3;
    i_hblank   = 1'b0;
    cen_cnt    = 0;
    cen_period = 4;
    repeat (100) step();
    chk("steady_n_loads", 32'(n_ld),      32'd4);
    chk("steady_row0",    32'(ld_log[1]), 32'h1234);
    chk("steady_row1",    32'(ld_log[2]), 32'h5678);
    chk("steady_row2",    32'(ld_log[3]), 32'h9ABC);
    for (int i = 1; i < 4; i++) chk($sformatf("steady_ldn_width%0d", i), 32'(low_dur[i]), 32'd4);
    chk("steady_spacing1", 32'(fall_at[2] - fall_at[1]), 32'd32);
    chk("steady_spacing2", 32'(fall_at[3] - fall_at[2]), 32'd32);
    chk("steady_addr0",    32'(ack_addr[0]), 32'h00FF);
    chk("steady_addr1",    32'(ack_addr[1]), 32'h0100);
    chk("steady_addr2",    32'(ack_addr[2]), 32'h0101);
    chk("steady_addr3",    32'(ack_addr[3]), 32'h0102);
    chk("steady_underrun", 32'(o_underrun),  32'h0);

    // ---- underrun: new line, ack latency 40, pxl_cen every 2 clks
    cen_period = 0;
    i_pxl_cen  = 1'b0;
    i_hblank   = 1'b1;
    repeat (4) step();
    rom_q.push_back(16'hC33C);
    rsp_lat      = 40;
    i_line_start = 1'b1;
    step();
    chk("ur_clrn_lo", 32'(o_sr_clrn), 32'h0);
    i_line_start = 1'b0;
    i_hblank     = 1'b0;
    cen_cnt      = 0;
    cen_period   = 2;
    repeat (16) step();
    chk("ur_flag",  32'(o_underrun), 32'h1);
    chk("ur_d0",    32'(o_sr_d0),    32'h00);
    chk("ur_d1",    32'(o_sr_d1),    32'h00);
    repeat (34) step();
    chk("ur_load_a",    32'(ld_log[4]), 32'h0000);
    chk("ur_load_b",    32'(ld_log[5]), 32'h0000);
    chk("ur_load_late", 32'(ld_log[6]), 32'hC33C);
    chk("ur_sticky",    32'(o_underrun), 32'h1);

    // ---- abort: line_start while a request is outstanding
    cen_period = 0;
    i_pxl_cen  = 1'b0;
    i_hblank   = 1'b1;
    rsp_en     = 1'b0;
    i_rom_ack  = 1'b0;
    chk("abort_req_pending", 32'(o_rom_req), 32'h1);
    i_tile_addr  = 16'h0200;
    i_line_start = 1'b1;
    step();
    i_line_start = 1'b0;
    chk("abort_req_kept",   32'(o_rom_req),  32'h1);
    chk("abort_ur_cleared", 32'(o_underrun), 32'h0);
    repeat (3) step();
    chk("abort_req_wait", 32'(o_rom_req), 32'h1);
    i_rom_ack  = 1'b1;
    i_rom_data = 16'hDEAD;
    step();
    i_rom_ack  = 1'b0;
    chk("abort_req_drop", 32'(o_rom_req), 32'h0);
    step();
    chk("abort_rereq",      32'(o_rom_req),  32'h1);
    chk("abort_rereq_addr", 32'(o_rom_addr), 32'h0200);
    i_rom_ack  = 1'b1;
    i_rom_data = 16'h3CC3;
    step();
    i_rom_ack  = 1'b0;
    i_pxl_cen  = 1'b1;
    step();
    i_pxl_cen  = 1'b0;
    chk("abort_prime_d0",  32'(o_sr_d0),     32'hC3);
    chk("abort_prime_d1",  32'(o_sr_d1),     32'h3C);
    chk("abort_prime_ldn", 32'(o_sr_sh_ldn), 32'h0);

    // ---- reset while a request is outstanding
    step();
    chk("mrst_req_before", 32'(o_rom_req), 32'h1);
    Reset_n = 1'b0;
    step();
    chk("mrst_req",  32'(o_rom_req),   32'h0);
    chk("mrst_ldn",  32'(o_sr_sh_ldn), 32'h1);
    chk("mrst_clrn", 32'(o_sr_clrn),   32'h0);
    chk("mrst_d0",   32'(o_sr_d0),     32'h00);
    i_tile_addr = 16'h03A0;
    Reset_n     = 1'b1;
    step();
    chk("mrst_rereq",      32'(o_rom_req),  32'h1);
    chk("mrst_rereq_addr", 32'(o_rom_addr), 32'h03A0);

    // ---- whole-run invariants
    chk("total_loads",   32'(n_ld),     32'd8);
    chk("abort_log",     32'(ld_log[7]), 32'h3CC3);
    chk("req_count",     32'(n_req),    32'd10);
    chk("adv_eq_req",    32'(n_adv),    32'(n_req));
    chk("sr_d_stable",   32'(d_glitch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
